// File: rtl/proj_pkg.sv
// Shared constants and types for the FM buffer sweep / MinHash path.
// Optional index-sequence checking in the collector is enabled by PROJ_MIN_SEQ_CHECK_EN.
package proj_pkg;

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int FM_BUFFER_SIZE = 8;
  localparam int FM_IDX_W       = idx_width(FM_BUFFER_SIZE);
  localparam int FM_VAL_W       = 8;

  typedef enum logic [1:0] {
    MC_IDLE,
    MC_SCAN,
    MC_HOLD
  } min_coll_state_t;

  typedef struct packed {
    logic [FM_VAL_W-1:0] value;
    logic [FM_IDX_W-1:0] index;
  } fm_min_t;

endpackage

// File: rtl/proj_min_cmp_update.sv
// Registered running-minimum holder: load takes the input unconditionally,
// update takes it only when strictly smaller, so on ties the earliest entry stays.
module proj_min_cmp_update #(
  parameter int VAL_W = proj_pkg::FM_VAL_W,
  parameter int IDX_W = proj_pkg::FM_IDX_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             upd_en_i,
  input  logic [VAL_W-1:0] value_i,
  input  logic [IDX_W-1:0] index_i,
  output logic [VAL_W-1:0] min_value_o,
  output logic [IDX_W-1:0] min_index_o
);

  logic [VAL_W-1:0] min_value_q, min_value_d;
  logic [IDX_W-1:0] min_index_q, min_index_d;

  // NOTE: every variable driven in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    min_value_d = min_value_q;
    min_index_d = min_index_q;
    if (load_i || (upd_en_i && (value_i < min_value_q))) begin
      min_value_d = value_i;
      min_index_d = index_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      min_value_q <= '0;
      min_index_q <= '0;
    end else begin
      min_value_q <= min_value_d;
      min_index_q <= min_index_d;
    end
  end

  assign min_value_o = min_value_q;
  assign min_index_o = min_index_q;

endmodule

// File: rtl/proj_min_collector.sv
// Collects the minimum (value, index) over one FM buffer sweep and offers it downstream.
// Define PROJ_MIN_SEQ_CHECK_EN to add the sticky index-sequence checker on seq_err.
module proj_min_collector #(
  parameter int FM_BUFFER_SIZE = proj_pkg::FM_BUFFER_SIZE,
  parameter int IDX_W          = proj_pkg::FM_IDX_W,
  parameter int VAL_W          = proj_pkg::FM_VAL_W
) (
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_index,
  input  logic [VAL_W-1:0] in_value,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [VAL_W-1:0] min_value,
  output logic [IDX_W-1:0] min_index,
  output logic             seq_err
);

  import proj_pkg::*;

  if (FM_BUFFER_SIZE < 1) begin : g_bad_size
    $error("proj_min_collector: FM_BUFFER_SIZE must be at least 1");
  end

  min_coll_state_t state_q, state_d;
  logic            accept;
  logic            load;
  logic            upd_en;

  assign accept = in_valid && (state_q != MC_HOLD);

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b1;
    out_valid = 1'b0;
    load      = 1'b0;
    upd_en    = 1'b0;
    case (state_q)
      MC_IDLE: begin
        // Only an index-0 beat can start a sweep; anything else is dropped here.
        if (accept && (in_index == '0)) begin
          load    = 1'b1;
          state_d = in_last ? MC_HOLD : MC_SCAN;
        end
      end
      MC_SCAN: begin
        if (accept) begin
          upd_en = 1'b1;
          if (in_last) state_d = MC_HOLD;
        end
      end
      MC_HOLD: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        if (out_ready) state_d = MC_IDLE;
      end
      default: state_d = MC_IDLE;
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) state_q <= MC_IDLE;
    else        state_q <= state_d;
  end

  proj_min_cmp_update #(
    .VAL_W (VAL_W),
    .IDX_W (IDX_W)
  ) u_cmp (
    .clk_i       (in_clk),
    .rst_i       (in_rst),
    .load_i      (load),
    .upd_en_i    (upd_en),
    .value_i     (in_value),
    .index_i     (in_index),
    .min_value_o (min_value),
    .min_index_o (min_index)
  );

`ifdef PROJ_MIN_SEQ_CHECK_EN
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FM_BUFFER_SIZE - 1);

  logic [IDX_W-1:0] exp_idx_q, exp_idx_d;
  logic             seq_err_q, seq_err_d;

  // Every accepted beat advances the expected index, including dropped IDLE beats.
  always_comb begin
    exp_idx_d = exp_idx_q;
    seq_err_d = seq_err_q;
    if (accept) begin
      exp_idx_d = (in_last || (exp_idx_q == LAST_IDX)) ? '0 : exp_idx_q + IDX_W'(1);
      if (in_index != exp_idx_q)                        seq_err_d = 1'b1;
      if ((state_q == MC_IDLE) && (in_index != '0))     seq_err_d = 1'b1;
      if (in_last && (in_index != LAST_IDX))            seq_err_d = 1'b1;
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      exp_idx_q <= '0;
      seq_err_q <= 1'b0;
    end else begin
      exp_idx_q <= exp_idx_d;
      seq_err_q <= seq_err_d;
    end
  end

  assign seq_err = seq_err_q;
`else
  assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_proj_min_collector.sv
// Scoreboard bench for proj_min_collector: the driver pushes the golden (min, index) of each
// sweep, a separate monitor pops and compares whenever a result is offered downstream.
module tb_proj_min_collector;
  import proj_pkg::*;

  localparam int N  = FM_BUFFER_SIZE;
  localparam int IW = FM_IDX_W;
  localparam int VW = FM_VAL_W;

  logic          in_clk = 1'b0;
  logic          in_rst;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_index;
  logic [VW-1:0] in_value;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] min_value;
  logic [IW-1:0] min_index;
  logic          seq_err;

  logic          man_ready;
  logic          rnd_ready;
  logic          bp_en;

  logic          b_valid, b_ready, b_index, b_last, b_out_valid, b_out_ready;
  logic          b_min_index, b_seq_err;
  logic [VW-1:0] b_value, b_min_value;

  always #5 in_clk = ~in_clk;

  assign out_ready = bp_en ? rnd_ready : man_ready;

  proj_min_collector #(.FM_BUFFER_SIZE(N), .IDX_W(IW), .VAL_W(VW)) dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_index(in_index), .in_value(in_value), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .min_value(min_value), .min_index(min_index), .seq_err(seq_err)
  );

  proj_min_collector #(.FM_BUFFER_SIZE(1), .IDX_W(1), .VAL_W(VW)) dut1 (
    .in_clk(in_clk), .in_rst(in_rst), .in_valid(b_valid), .in_ready(b_ready),
    .in_index(b_index), .in_value(b_value), .in_last(b_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .min_value(b_min_value), .min_index(b_min_index), .seq_err(b_seq_err)
  );

  int checks = 0;
  int errors = 0;
  int pushed = 0;
  int results = 0;
  fm_min_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Golden: smallest value of the sweep, reported at its first occurrence.
  function automatic fm_min_t golden(input int idxs[$], input int vals[$]);
    fm_min_t r;
    int mq[$];
    int fi[$];
    mq = vals.min();
    fi = vals.find_first_index(x) with (x == mq[0]);
    r.value = VW'(mq[0]);
    r.index = IW'(idxs[fi[0]]);
    return r;
  endfunction

  always @(posedge in_clk) begin
    #1 rnd_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: compares every cycle a result is offered (stability under backpressure too).
  always @(negedge in_clk) begin
    if (!in_rst && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got value 0x%0h index %0d with nothing expected",
                 min_value, min_index);
      end else begin
        check("min_value", min_value, exp_q[0].value);
        check("min_index", min_index, exp_q[0].index);
`ifndef PROJ_MIN_SEQ_CHECK_EN
        check("seq_err_tied", seq_err, 0);
`endif
        if (out_ready) begin
          void'(exp_q.pop_front());
          results++;
        end
      end
    end
  end

  task automatic send_beat(input int idx, input int val, input bit last, output int waited);
    in_valid = 1'b1;
    in_index = IW'(idx);
    in_value = VW'(val);
    in_last  = last;
    waited   = 0;
    forever begin
      @(negedge in_clk);
      if (in_ready) break;
      waited++;
      if (waited > 200) begin
        checks++;
        errors++;
        $display("FAIL beat_timeout: index %0d never accepted", idx);
        break;
      end
    end
    @(posedge in_clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_sweep(input int idxs[$], input int vals[$], output int first_wait);
    int w;
    bit last;
    first_wait = 0;
    for (int k = 0; k < idxs.size(); k++) begin
      last = (k == idxs.size() - 1);
      if (last) begin
        exp_q.push_back(golden(idxs, vals));
        pushed++;
      end
      send_beat(idxs[k], vals[k], last, w);
      if (k == 0) first_wait = w;
    end
    @(negedge in_clk);
    check("latency_out_valid", out_valid, 1);
    @(posedge in_clk);
    #1;
  endtask

  task automatic do_reset();
    in_rst = 1'b1;
    @(posedge in_clk);
    #1;
    in_rst = 1'b0;
    @(negedge in_clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_min_value", min_value, 0);
    check("rst_min_index", min_index, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_seq_err", seq_err, 0);
    @(posedge in_clk);
    #1;
  endtask

  function automatic void seq_idx(output int q[$]);
    q = {};
    for (int k = 0; k < N; k++) q.push_back(k);
  endfunction

  initial begin
    int idxs[$];
    int vals[$];
    int w;
    int exp_seq;

    in_rst = 1'b1; in_valid = 1'b0; in_index = '0; in_value = '0; in_last = 1'b0;
    man_ready = 1'b1; bp_en = 1'b0;
    b_valid = 1'b0; b_index = 1'b0; b_value = '0; b_last = 1'b0; b_out_ready = 1'b1;
    repeat (2) @(posedge in_clk);
    #1;
    do_reset();

    // Single sweep with an early tie on the minimum.
    seq_idx(idxs);
    vals = '{9, 4, 7, 4, 12, 3, 3, 8};
    send_sweep(idxs, vals, w);
    @(negedge in_clk);
    check("out_valid_one_cycle", out_valid, 0);
    @(posedge in_clk);
    #1;

    // Backpressure: result held 5 cycles while the next beat 0 waits.
    man_ready = 1'b0;
    send_sweep(idxs, vals, w);
    in_valid = 1'b1; in_index = '0; in_value = 8'h20; in_last = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge in_clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
    end
    @(posedge in_clk);
    #1;
    man_ready = 1'b1;
    vals = '{32, 200, 17, 99, 17, 250, 18, 40};
    send_sweep(idxs, vals, w);
    check("bp_accept_delay", w, 1);

    // Reset mid-sweep with a stale small minimum already captured.
    send_beat(0, 8'h80, 1'b0, w);
    send_beat(1, 8'h00, 1'b0, w);
    send_beat(2, 8'h40, 1'b0, w);
    send_beat(3, 8'h10, 1'b0, w);
    do_reset();
    vals = {};
    for (int k = 0; k < N; k++) vals.push_back(k == 6 ? 8'h01 : 8'hFF);
    send_sweep(idxs, vals, w);

    // Depth-1 instance: each index-0 beat with in_last is a complete sweep.
    for (int k = 0; k < 4; k++) begin
      int v;
      v = (k == 0) ? 8'h55 : int'($urandom_range(0, 255));
      b_valid = 1'b1; b_index = 1'b0; b_value = VW'(v); b_last = 1'b1;
      @(negedge in_clk);
      check("d1_in_ready", b_ready, 1);
      @(posedge in_clk);
      #1;
      b_valid = 1'b0; b_last = 1'b0;
      @(negedge in_clk);
      check("d1_out_valid", b_out_valid, 1);
      check("d1_min_value", b_min_value, v);
      check("d1_min_index", b_min_index, 0);
      check("d1_seq_err", b_seq_err, 0);
      @(posedge in_clk);
      #1;
    end

    // Index sequence with a skipped index and a wrong last index.
    do_reset();
    idxs = '{0, 1, 2, 4, 5, 6, 7, 0};
    vals = {};
    for (int k = 0; k < 8; k++) vals.push_back(int'($urandom_range(0, 255)));
    for (int k = 0; k < 8; k++) begin
`ifdef PROJ_MIN_SEQ_CHECK_EN
      exp_seq = (k >= 3) ? 1 : 0;
`else
      exp_seq = 0;
`endif
      if (k == 7) begin
        exp_q.push_back(golden(idxs, vals));
        pushed++;
      end
      send_beat(idxs[k], vals[k], k == 7, w);
      check("seq_err_track", seq_err, exp_seq);
    end
    @(negedge in_clk);
    check("seq_latency_out_valid", out_valid, 1);
    @(posedge in_clk);
    #1;
    do_reset();

    // Idle drop: stray nonzero-index beat (with in_last) then one clean sweep.
    send_beat(3, 8'h00, 1'b1, w);
    @(negedge in_clk);
    check("idle_drop_no_result", out_valid, 0);
    check("idle_drop_ready", in_ready, 1);
    @(posedge in_clk);
    #1;
    seq_idx(idxs);
    vals = {};
    for (int k = 0; k < N; k++) vals.push_back(int'($urandom_range(1, 255)));
    send_sweep(idxs, vals, w);

    // Randomized sweeps with random backpressure, narrow value ranges to force ties.
    bp_en = 1'b1;
    for (int s = 0; s < 25; s++) begin
      if ($urandom_range(0, 3) == 0)
        send_beat(int'($urandom_range(1, N - 1)), int'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), w);
      vals = {};
      for (int k = 0; k < N; k++)
        vals.push_back((s % 2 == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 255)));
      send_sweep(idxs, vals, w);
    end
    bp_en = 1'b0;

    // Drain: everything pushed must have been presented and taken.
    for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(posedge in_clk);
    @(negedge in_clk);
    check("pending_results", exp_q.size(), 0);
    check("result_count", results, pushed);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end

endmodule

// File: doc/proj_min_collector.md
Name: proj_min_collector

Overview:
- Consumer end of the FM buffer index sweep: takes the stream of (index, value) beats and the end-of-sweep marker that the sweep counter produces.
- Tracks the minimum value over one full FM buffer sweep and the index where that minimum occurred.
- Presents the (min_value, min_index) pair with a valid/ready handshake; this is the per-buffer MinHash signature element passed downstream.

Parameters:
- FM_BUFFER_SIZE, proj_pkg::FM_BUFFER_SIZE, number of entries per FM buffer sweep (≥1)
- IDX_W, proj_pkg::FM_IDX_W, index width = max(1, $clog2(FM_BUFFER_SIZE))
- VAL_W, proj_pkg::FM_VAL_W, width of each hashed value

Ports:
- in_clk, input, 1, clock
- in_rst, input, 1, reset; synchronous, active-high
- in_valid, input, 1, beat present on in_index/in_value
- in_ready, output, 1, block accepts a beat this cycle
- in_index, input, IDX_W, buffer index of the beat
- in_value, input, VAL_W, hashed value of the beat
- in_last, input, 1, final beat of the sweep (finished_count)
- out_valid, output, 1, result available
- out_ready, input, 1, downstream takes the result
- min_value, output, VAL_W, minimum value of the sweep
- min_index, output, IDX_W, index of the minimum
- seq_err, output, 1, sticky index-sequence error (feature only; tied 0 otherwise)

Behaviour:
- Clocking and reset: one clock, in_clk. Reset is in_rst, synchronous and active-high, sampled on the in_clk rising edge.
- Reset response: state = IDLE, out_valid = 0, min_value = 0, min_index = 0, seq_err = 0, in_ready = 1 in the following cycle. Reset overrides all other inputs, including mid-sweep and during HOLD; any partial result is discarded.
- Beat acceptance: a beat is accepted when in_valid & in_ready; in_ready = (state != HOLD).
- FSM IDLE:
  - Accepted beat with in_index == 0: load min_value = in_value, min_index = 0.
  - Go to HOLD if in_last is also high, which covers FM_BUFFER_SIZE == 1; otherwise go to SCAN.
  - Accepted beat with in_index != 0: dropped; stay in IDLE.
- FSM SCAN:
  - Each accepted beat updates the running minimum if in_value < min_value (unsigned, strict). On equal values the earliest index wins.
  - An accepted beat with in_last high is included in the comparison, then the FSM goes to HOLD.
- FSM HOLD:
  - out_valid = 1; min_value and min_index are stable; in_ready = 0.
  - When out_ready is high, go to IDLE and drop out_valid next cycle.
  - A beat presented in HOLD is not accepted. Upstream holds it, and it is accepted in IDLE the next cycle.
- Latency: out_valid rises exactly 1 cycle after the in_last beat is accepted. Back-to-back sweeps lose exactly one cycle when out_ready is held high.
- out_ready outside HOLD is ignored.
- in_last in IDLE on a beat with nonzero index: the beat is dropped; no result is produced.
- Widths: comparisons are unsigned over VAL_W bits; there is no arithmetic on values. Index values pass through unchanged.

Optional Feature:
- Macro: PROJ_MIN_SEQ_CHECK_EN.
- Defined:
  - An IDX_W expected-index register resets to 0, increments on each accepted beat, and wraps to 0 after FM_BUFFER_SIZE-1 or after in_last.
  - seq_err sets and stays set until in_rst on any of:
    - an accepted beat with in_index != expected;
    - an IDLE beat with nonzero index being dropped;
    - in_last on a beat whose index != FM_BUFFER_SIZE-1.
  - seq_err does not alter min tracking.
- Undefined: no expected-index register; seq_err is driven 0.

Decomposition:
- proj_pkg gains:
  - FM_IDX_W and FM_VAL_W constants;
  - typedef enum logic [1:0] {MC_IDLE, MC_SCAN, MC_HOLD} min_coll_state_t;
  - typedef struct packed {value, index} fm_min_t for the result pair.
- One sub-module: proj_min_cmp_update, a registered running-minimum holder with load, update-enable and strict-less compare, reused by later multi-hash lanes.

Test Plan:
- Single sweep, FM_BUFFER_SIZE=8, values {9,4,7,4,12,3,3,8}, indices 0..7, in_last on 7, out_ready=1. Required: out_valid 1 cycle after beat 7; min_value=3, min_index=5 (earliest tie); out_valid high 1 cycle.
- Backpressure: same sweep with out_ready=0 for 5 cycles after completion, and the next sweep's beat 0 presented. Required: in_ready=0 and the result stable for 5 cycles; the new beat 0 is accepted the cycle after out_ready rises.
- Reset mid-sweep: in_rst high after index 3 of the first sweep, then a full sweep of all 0xFF except index 6 = 0x01. Required: min_value=0x01, min_index=6; no stale minimum from before reset.
- Depth-1 sweep, FM_BUFFER_SIZE=1: a beat with index 0, value 0x55 and in_last=1. Required: out_valid next cycle, min_value=0x55, min_index=0.
- Sequence error (PROJ_MIN_SEQ_CHECK_EN defined), FM_BUFFER_SIZE=8: indices 0,1,2,4,5,6,7,0 with in_last on the 8th beat (index 0). Required: seq_err=1 from the cycle after index 4 is accepted until in_rst; the result is still produced.
- Idle drop: a beat with index 3 while in IDLE, followed by a clean sweep 0..7. Required: the index-3 beat is ignored, exactly one result is produced, and it matches a golden model of the clean sweep.
